spi_cmd_master: RTL and testbench

On-chip SPI command master that produces the 40-bit command frames consumed by the flash-programming SPI slave: an 8-bit command followed by a 32-bit payload, MSB first. A local request/response port lets on-chip logic issue reads and writes of datecode, status, control, address and flash data without an external host. The block drives `spi_clk`, `spi_en_n` and `spi_mosi`, and captures the 32-bit readback on `spi_miso`.

---
 rtl/spi_cmd_pkg.sv | 23 ++
 rtl/spi_cmd_sck_gen.sv | 45 ++++
 rtl/spi_cmd_master.sv | 171 +++++++++++++++++
 tb/tb_spi_cmd_master.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_pkg.sv
// Shared constants and FSM state type for the SPI command master.
package spi_cmd_pkg;

  localparam logic [7:0] CMD_DATECODE = 8'h01;
  localparam logic [7:0] CMD_CTRL_WR  = 8'h03;
  localparam logic [7:0] CMD_ADDR_WR  = 8'h04;
  localparam logic [7:0] CMD_ADDR_RD  = 8'h05;
  localparam logic [7:0] CMD_DATA_WR  = 8'h06;
  localparam logic [7:0] CMD_DATA_LD  = 8'h07;
  localparam logic [7:0] CMD_RDATA_RD = 8'h08;

  localparam int unsigned FRAME_BITS    = 40;
  localparam int unsigned RSP_FIRST_BIT = 9;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShift,
    StHold,
    StGap
  } state_e;

endpackage

// File: rtl/spi_cmd_sck_gen.sv
// SCK generator: half-period counter with rise/fall ticks that announce the next SCK edge.
module spi_cmd_sck_gen #(
  parameter int unsigned ClkDiv = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic rise_tick_o,
  output logic fall_tick_o,
  output logic spi_clk_o
);
  localparam int unsigned CntW = $clog2(ClkDiv);
  localparam logic [CntW-1:0] CntLast = CntW'(ClkDiv - 1);
  // Starting at 1 makes the first edge land ClkDiv cycles after chip select drops.
  localparam logic [CntW-1:0] CntStart = CntW'(1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            spi_clk_q, spi_clk_d;
  logic            tick;

  always_comb begin
    tick      = en_i && (cnt_q == CntLast);
    cnt_d     = CntStart;
    spi_clk_d = 1'b0;
    if (en_i) begin
      cnt_d     = tick ? '0 : cnt_q + CntW'(1);
      spi_clk_d = spi_clk_q ^ tick;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= CntStart;
      spi_clk_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      spi_clk_q <= spi_clk_d;
    end
  end

  assign rise_tick_o = tick & ~spi_clk_q;
  assign fall_tick_o = tick & spi_clk_q;
  assign spi_clk_o   = spi_clk_q;

endmodule

// File: rtl/spi_cmd_master.sv
// On-chip SPI mode-0 master issuing 40-bit {cmd, payload} frames and capturing a 32-bit readback.
// Define SPI_CMD_MASTER_MISO_SYNC_EN to pass MISO through a 2-flop synchronizer.
module spi_cmd_master
  import spi_cmd_pkg::*;
#(
  parameter int unsigned CLK_DIV = 8,
  parameter int unsigned CS_GAP  = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [7:0]  req_cmd_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        spi_clk_o,
  output logic        spi_en_n_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i
);
  localparam int unsigned HoldW = $clog2(CLK_DIV);
  localparam int unsigned GapW  = $clog2(CS_GAP + 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(CLK_DIV - 1);
  localparam logic [GapW-1:0]  GapLast  = GapW'(CS_GAP - 1);
  localparam logic [5:0]       LastBit  = 6'(FRAME_BITS);
  localparam logic [5:0]       FirstRsp = 6'(RSP_FIRST_BIT);

  state_e            state_q, state_d;
  logic [39:0]       frame_q, frame_d;
  logic [31:0]       rx_q, rx_d, rdata_q, rdata_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;
  logic [HoldW-1:0]  hold_cnt_q, hold_cnt_d;
  logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
  logic              mosi_q, mosi_d, en_n_q, en_n_d, ready_q, ready_d, rsp_valid_q, rsp_valid_d;
  logic              rise_tick, fall_tick, sample_en, miso_s;

  spi_cmd_sck_gen #(
    .ClkDiv(CLK_DIV)
  ) u_sck_gen (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .en_i       (state_q == StShift),
    .rise_tick_o(rise_tick),
    .fall_tick_o(fall_tick),
    .spi_clk_o  (spi_clk_o)
  );

`ifdef SPI_CMD_MASTER_MISO_SYNC_EN
  logic [1:0] miso_sync_q;
  logic [2:0] rise_pipe_q;
  // Sampling trails the rise by two extra cycles so it lines up with the synchronizer delay.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      miso_sync_q <= '0;
      rise_pipe_q <= '0;
    end else begin
      miso_sync_q <= {miso_sync_q[0], spi_miso_i};
      rise_pipe_q <= {rise_pipe_q[1:0], rise_tick};
    end
  end
  assign sample_en = rise_pipe_q[2];
  assign miso_s    = miso_sync_q[1];
`else
  logic rise_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rise_q <= 1'b0;
    else       rise_q <= rise_tick;
  end
  assign sample_en = rise_q;
  assign miso_s    = spi_miso_i;
`endif

  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    rx_d        = rx_q;
    rdata_d     = rdata_q;
    bit_cnt_d   = bit_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    mosi_d      = mosi_q;
    en_n_d      = en_n_q;
    ready_d     = ready_q;
    rsp_valid_d = 1'b0;

    // Rises 1..8 carry the command byte; the slave's readback starts at rise 9.
    if (sample_en && (bit_cnt_q >= FirstRsp)) rx_d = {rx_q[30:0], miso_s};

    unique case (state_q)
      StIdle: begin
        if (req_valid_i && ready_q) begin
          state_d   = StSetup;
          frame_d   = {req_cmd_i, req_wdata_i};
          mosi_d    = req_cmd_i[7];
          en_n_d    = 1'b0;
          ready_d   = 1'b0;
          bit_cnt_d = '0;
          rx_d      = '0;
        end
      end
      StSetup: state_d = StShift;
      StShift: begin
        if (rise_tick && (bit_cnt_q < LastBit)) bit_cnt_d = bit_cnt_q + 6'd1;
        if (fall_tick) begin
          frame_d = {frame_q[38:0], 1'b0};
          mosi_d  = (bit_cnt_q < LastBit) ? frame_q[38] : 1'b0;
          if (bit_cnt_q == LastBit) begin
            state_d    = StHold;
            hold_cnt_d = '0;
          end
        end
      end
      StHold: begin
        if (hold_cnt_q == HoldLast) begin
          state_d     = StGap;
          en_n_d      = 1'b1;
          rsp_valid_d = 1'b1;
          rdata_d     = rx_q;
          gap_cnt_d   = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          state_d = StIdle;
          ready_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      frame_q     <= '0;
      rx_q        <= '0;
      rdata_q     <= '0;
      bit_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      mosi_q      <= 1'b0;
      en_n_q      <= 1'b1;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      rx_q        <= rx_d;
      rdata_q     <= rdata_d;
      bit_cnt_q   <= bit_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      mosi_q      <= mosi_d;
      en_n_q      <= en_n_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign spi_en_n_o  = en_n_q;
  assign spi_mosi_o  = mosi_q;

endmodule

// File: tb/tb_spi_cmd_master.sv
// Randomized bench: SPI slave model plus a per-cycle timing reference for spi_cmd_master.
module tb_spi_cmd_master;
  import spi_cmd_pkg::*;

`ifdef SPI_CMD_MASTER_MISO_SYNC_EN
  localparam int unsigned CLK_DIV = 4;
`else
  localparam int unsigned CLK_DIV = 8;
`endif
  localparam int unsigned CS_GAP  = 16;
  localparam int          FRAME_T = 81 * CLK_DIV;
  localparam logic [31:0] DATECODE  = 32'h8002_3456;
  localparam logic [31:0] STATUS    = 32'h0000_00A5;
  localparam logic [31:0] FLASH     = 32'h1357_9BDF;
  localparam logic [31:0] ADDR_INIT = 32'h0000_0C00;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_ready, rsp_valid, spi_clk, spi_en_n, spi_mosi, spi_miso;
  logic [7:0]  req_cmd;
  logic [31:0] req_wdata, rsp_rdata;

  always #5 clk = ~clk;

  spi_cmd_master #(
    .CLK_DIV(CLK_DIV),
    .CS_GAP (CS_GAP)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_cmd_i  (req_cmd),
    .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid),
    .rsp_rdata_o(rsp_rdata),
    .spi_clk_o  (spi_clk),
    .spi_en_n_o (spi_en_n),
    .spi_mosi_o (spi_mosi),
    .spi_miso_i (spi_miso)
  );

  function automatic logic [31:0] readback(input logic [7:0] cmd, input logic [31:0] addr);
    case (cmd)
      CMD_DATECODE: return DATECODE;
      CMD_ADDR_RD:  return addr;
      CMD_RDATA_RD: return FLASH;
      default:      return STATUS;
    endcase
  endfunction

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Slave: shifts MOSI in on rises, presents readback bit 31 after fall 8, one bit per fall.
  logic [39:0] s_frame = '0, s_last_frame = '0;
  logic [31:0] s_rb = '0, s_addr = ADDR_INIT;
  int          s_rises = 0, s_falls = 0, s_last_rises = 0;
  logic        s_prev_clk = 1'b0, s_prev_en = 1'b1;

  initial begin
    spi_miso = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (spi_en_n) begin
        if (!s_prev_en) begin
          s_last_frame = s_frame;
          s_last_rises = s_rises;
          if (s_rises == 40 && s_frame[39:32] == CMD_ADDR_WR) s_addr = s_frame[31:0];
        end
        s_rises  = 0;
        s_falls  = 0;
        spi_miso = 1'b0;
      end else begin
        if (spi_clk && !s_prev_clk) begin
          s_rises++;
          s_frame = {s_frame[38:0], spi_mosi};
          if (s_rises == 8) s_rb = readback(s_frame[7:0], s_addr);
        end
        if (!spi_clk && s_prev_clk) begin
          s_falls++;
          if (s_falls >= 8 && s_falls < 40) spi_miso = s_rb[39-s_falls];
        end
      end
      s_prev_clk = spi_clk;
      s_prev_en  = spi_en_n;
    end
  end

  // Reference: outputs as a function of cycles since the accept cycle.
  logic        m_active = 1'b0;
  int          m_a = 0, m_idx = 0, fidx = 0;
  logic [39:0] m_frame = '0;
  logic [31:0] m_rdata = '0, m_addr = ADDR_INIT;
  int          en_low_run = 0, last_rise_cyc = -1000;
  logic        prev_en_n = 1'b1;

  always @(negedge clk) begin
    logic e_en_n, e_clk, e_mosi, e_ready, e_valid;
    int   t, p, m;
    e_en_n = 1'b1; e_clk = 1'b0; e_mosi = 1'b0; e_ready = 1'b1; e_valid = 1'b0;
    if (rst) begin
      m_active = 1'b0;
      m_rdata  = '0;
    end else if (m_active) begin
      t = cyc - m_a;
      if (t == 1 + FRAME_T + CS_GAP) begin
        m_active = 1'b0;
      end else begin
        e_ready = 1'b0;
        if (t >= 1 && t <= FRAME_T) begin
          p      = (t - 1) / CLK_DIV;
          m      = (t - 1) / (2 * CLK_DIV);
          e_en_n = 1'b0;
          e_clk  = (p % 2) == 1;
          e_mosi = (m < 40) ? m_frame[39-m] : 1'b0;
        end else if (t == FRAME_T + 1) begin
          e_valid = 1'b1;
          m_rdata = readback(m_frame[39:32], m_addr);
          if (m_frame[39:32] == CMD_ADDR_WR) m_addr = m_frame[31:0];
        end
      end
    end

    chk("spi_en_n", 40'(spi_en_n), 40'(e_en_n));
    chk("spi_clk", 40'(spi_clk), 40'(e_clk));
    chk("spi_mosi", 40'(spi_mosi), 40'(e_mosi));
    chk("req_ready", 40'(req_ready), 40'(e_ready));
    chk("rsp_valid", 40'(rsp_valid), 40'(e_valid));
    chk("rsp_rdata", 40'(rsp_rdata), 40'(m_rdata));

    if (e_valid) begin
      chk("slave_frame", s_last_frame, m_frame);
      chk("sck_pulses", 40'(s_last_rises), 40'd40);
      chk("en_low_cycles", 40'(en_low_run), 40'(FRAME_T));
      if (m_idx == 0) chk("datecode_rdata", 40'(rsp_rdata), 40'h00_8002_3456);
      if (m_idx == 1) chk("addr_rd_rdata", 40'(rsp_rdata), 40'h00_0000_0C00);
      if (m_idx == 2) chk("addr_wr_frame", s_last_frame, 40'h04_0000_1234);
    end

    if (!spi_en_n && prev_en_n) begin
      if (m_active && m_idx == 4) chk("b2b_gap", 40'(cyc - last_rise_cyc), 40'd17);
      en_low_run = 0;
    end
    if (!spi_en_n) en_low_run++;
    if (spi_en_n && !prev_en_n) last_rise_cyc = cyc;
    prev_en_n = spi_en_n;

    if (!rst && e_ready && req_valid) begin
      m_active = 1'b1;
      m_a      = cyc;
      m_frame  = {req_cmd, req_wdata};
      m_idx    = fidx;
      fidx++;
    end
  end

  function automatic logic [7:0] rand_cmd();
    logic [7:0] tbl [7] = '{CMD_DATECODE, CMD_CTRL_WR, CMD_ADDR_WR, CMD_ADDR_RD,
                            CMD_DATA_WR, CMD_DATA_LD, CMD_RDATA_RD};
    int k = $urandom_range(0, 7);
    return (k == 7) ? 8'($urandom) : tbl[k];
  endfunction

  // Called #1 after a posedge; returns #1 after the posedge that accepted the request.
  task automatic send(input logic [7:0] c, input logic [31:0] w);
    req_cmd   = c;
    req_wdata = w;
    req_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    $display("FAIL send_timeout: req_ready stayed 0, want 1");
    $fatal(1, "no accept");
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (req_ready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    $display("FAIL idle_timeout: req_ready stayed 0, want 1");
    $fatal(1, "no idle");
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_cmd = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send(CMD_DATECODE, 32'h0);           req_valid = 1'b0; wait_idle();
    send(CMD_ADDR_RD, $urandom);         req_valid = 1'b0; wait_idle();
    send(CMD_ADDR_WR, 32'h0000_1234);    req_valid = 1'b0; wait_idle();
    send(rand_cmd(), $urandom);
    send(rand_cmd(), $urandom);          req_valid = 1'b0; wait_idle();
    // Request pulsed mid-shift must be ignored.
    send(rand_cmd(), $urandom);
    req_valid = 1'b0;
    repeat (20 * CLK_DIV) @(posedge clk);
    #1 req_valid = 1'b1; req_cmd = CMD_DATA_WR; req_wdata = $urandom;
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_idle();
    // Reset just after rise 20.
    send(rand_cmd(), $urandom);
    req_valid = 1'b0;
    repeat (39 * CLK_DIV + 2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send(rand_cmd(), $urandom);
      if ($urandom_range(0, 2) != 0) begin
        req_valid = 1'b0;
        repeat ($urandom_range(0, 40)) @(posedge clk);
        #1;
      end
    end
    req_valid = 1'b0;
    wait_idle();
    repeat (10) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
